// File: rtl/rabbit_frame_reader.sv
// Rabbit serial frame deserialiser: captures NUM_WORDS words of WORD_W bits per frame for the DDS FTW path.
// Define READER_PARITY_EN to add an even-parity bit after every word and reject frames that fail it.
module rabbit_frame_reader #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 2,
    parameter int FRAME_LEN = 184,
    parameter int START_BIT = 120,
    parameter int MSB_FIRST = 1
) (
    input  logic                        SCLK_PE3,
    input  logic                        RST_N,
    input  logic                        SDIO_PE5,
    input  logic                        SYNC_PE4,
    output logic [NUM_WORDS*WORD_W-1:0] DATA_OUT,
    output logic                        FRAME_VALID,
    output logic [15:0]                 FRAME_COUNT,
    output logic                        PARITY_ERR
);

`ifdef READER_PARITY_EN
    localparam int STRIDE  = WORD_W + 1;
`else
    localparam int STRIDE  = WORD_W;
`endif
    localparam int END_BIT = START_BIT + NUM_WORDS * STRIDE;
    localparam int TOTAL_W = NUM_WORDS * WORD_W;
    localparam int CNT_W   = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(FRAME_LEN - 1);
    localparam logic [TOTAL_W-1:0] ONE_HOT  = TOTAL_W'(1);

    logic [CNT_W-1:0]   bit_cnt;
    logic [TOTAL_W-1:0] shadow;
    logic [TOTAL_W-1:0] shadow_next;
    int                 n;
    int                 offset;
    int                 word_idx;
    int                 pos;
    int                 bit_idx;
    logic               in_window;
    logic               at_end;
    logic               is_data;

    // Decode the current bit index into word / bit position inside the capture window.
    always_comb begin
        n         = int'(bit_cnt);
        in_window = (n >= START_BIT) && (n < END_BIT);
        at_end    = (n == END_BIT);
        offset    = n - START_BIT;
        word_idx  = offset / STRIDE;
        pos       = offset % STRIDE;
        is_data   = in_window && (pos < WORD_W);
        bit_idx   = word_idx * WORD_W + ((MSB_FIRST != 0) ? (WORD_W - 1 - pos) : pos);
        shadow_next = (bit_cnt == '0) ? '0 : shadow;
        if (is_data) begin
            shadow_next = (shadow_next & ~(ONE_HOT << bit_idx))
                        | (TOTAL_W'(SDIO_PE5) << bit_idx);
        end
    end

`ifdef READER_PARITY_EN
    logic par_acc;
    logic par_next;
    logic err;
    logic err_next;

    // Running parity per word; the trailing bit must make the word+parity XOR to zero.
    always_comb begin
        par_next = par_acc;
        err_next = (bit_cnt == '0) ? 1'b0 : err;
        if (in_window) begin
            if (pos == 0) begin
                par_next = SDIO_PE5;
            end else if (pos < WORD_W) begin
                par_next = par_acc ^ SDIO_PE5;
            end else if ((par_acc ^ SDIO_PE5) == 1'b1) begin
                err_next = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge SCLK_PE3) begin
        if (!RST_N) begin
            bit_cnt     <= '0;
            shadow      <= '0;
            DATA_OUT    <= '0;
            FRAME_VALID <= 1'b0;
            FRAME_COUNT <= 16'd0;
`ifdef READER_PARITY_EN
            par_acc     <= 1'b0;
            err         <= 1'b0;
            PARITY_ERR  <= 1'b0;
`endif
        end else if (SYNC_PE4) begin
            // The sync edge is bit 0 of a fresh frame; any partial capture is dropped.
            bit_cnt     <= CNT_W'(1);
            shadow      <= '0;
            FRAME_VALID <= 1'b0;
`ifdef READER_PARITY_EN
            par_acc     <= 1'b0;
            err         <= 1'b0;
            PARITY_ERR  <= 1'b0;
`endif
        end else begin
            bit_cnt     <= (bit_cnt == LAST_CNT) ? '0 : bit_cnt + 1'b1;
            shadow      <= shadow_next;
            FRAME_VALID <= 1'b0;
`ifdef READER_PARITY_EN
            par_acc     <= par_next;
            err         <= err_next;
            PARITY_ERR  <= 1'b0;
            if (at_end) begin
                if (err) begin
                    PARITY_ERR  <= 1'b1;
                end else begin
                    DATA_OUT    <= shadow;
                    FRAME_VALID <= 1'b1;
                    FRAME_COUNT <= FRAME_COUNT + 16'd1;
                end
            end
`else
            if (at_end) begin
                DATA_OUT    <= shadow;
                FRAME_VALID <= 1'b1;
                FRAME_COUNT <= FRAME_COUNT + 16'd1;
            end
`endif
        end
    end

`ifndef READER_PARITY_EN
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_rabbit_frame_reader.sv
// Randomised frame-level bench for rabbit_frame_reader: one MSB-first two-word instance
// and one LSB-first single-word instance, checked against a frame-building reference model.
module tb_rabbit_frame_reader;

    localparam int WORD_W = 32;
    localparam int M_NW = 2;
    localparam int M_FL = 200;
    localparam int M_SB = 120;
    localparam int L_NW = 1;
    localparam int L_FL = 64;
    localparam int L_SB = 8;
`ifdef READER_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
    localparam int STRIDE    = WORD_W + 1;
`else
    localparam bit PARITY_ON = 1'b0;
    localparam int STRIDE    = WORD_W;
`endif
    localparam int M_END = M_SB + M_NW * STRIDE;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        sdio  = 1'b0;
    logic        sync  = 1'b0;
    logic [63:0] m_data;
    logic        m_valid;
    logic [15:0] m_count;
    logic        m_perr;
    logic [31:0] l_data;
    logic        l_valid;
    logic [15:0] l_count;
    logic        l_perr;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_vcyc = -1;
    int          prev_vcyc = -1;
    logic [63:0] exp_data [2];
    logic [15:0] exp_count [2];

    rabbit_frame_reader #(.WORD_W(WORD_W), .NUM_WORDS(M_NW), .FRAME_LEN(M_FL),
                          .START_BIT(M_SB), .MSB_FIRST(1)) u_main (
        .SCLK_PE3(clk), .RST_N(rst_n), .SDIO_PE5(sdio), .SYNC_PE4(sync),
        .DATA_OUT(m_data), .FRAME_VALID(m_valid), .FRAME_COUNT(m_count), .PARITY_ERR(m_perr)
    );

    rabbit_frame_reader #(.WORD_W(WORD_W), .NUM_WORDS(L_NW), .FRAME_LEN(L_FL),
                          .START_BIT(L_SB), .MSB_FIRST(0)) u_lsb (
        .SCLK_PE3(clk), .RST_N(rst_n), .SDIO_PE5(sdio), .SYNC_PE4(sync),
        .DATA_OUT(l_data), .FRAME_VALID(l_valid), .FRAME_COUNT(l_count), .PARITY_ERR(l_perr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sync  = 1'b0;
        sdio  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            exp_data[s]  = 64'h0;
            exp_count[s] = 16'h0;
        end
        check_val("rst_data", m_data, 64'h0);
        check_val("rst_count", 64'(m_count), 64'h0);
        check_val("rst_valid", 64'(m_valid), 64'h0);
        check_val("rst_perr", 64'(m_perr), 64'h0);
        check_val("rst_lsb_data", 64'(l_data), 64'h0);
        rst_n = 1'b1;
    endtask

    // Builds the whole frame as a bit list (filler, words, optional parity, filler),
    // streams the first nbits of it and checks every output after every edge.
    task automatic send_frame(input int sel, input logic [31:0] w0, input logic [31:0] w1,
                              input int nbits, input bit first_sync, input int bad_word);
        bit          q[$];
        int          fl;
        int          sb;
        int          nw;
        int          end_idx;
        bit          msb;
        bit          bad;
        logic [31:0] w;
        logic [63:0] obs_data;
        logic        obs_valid;
        logic        obs_perr;
        logic [15:0] obs_count;
        fl      = (sel != 0) ? L_FL : M_FL;
        sb      = (sel != 0) ? L_SB : M_SB;
        nw      = (sel != 0) ? L_NW : M_NW;
        msb     = (sel == 0);
        end_idx = sb + nw * STRIDE;
        bad     = PARITY_ON && (bad_word >= 0) && (bad_word < nw);
        for (int i = 0; i < sb; i++) q.push_back(1'($urandom));
        for (int k = 0; k < nw; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int j = 0; j < WORD_W; j++)
                q.push_back(msb ? 1'(w >> (WORD_W - 1 - j)) : 1'(w >> j));
            if (PARITY_ON) q.push_back((^w) ^ (k == bad_word));
        end
        while (q.size() < fl) q.push_back(1'($urandom));
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            sdio = q[i];
            sync = first_sync && (i == 0);
            @(posedge clk);
            #1;
            if (i == end_idx && !bad) begin
                exp_data[sel]  = (nw == 1) ? {32'h0, w0} : {w1, w0};
                exp_count[sel] = exp_count[sel] + 16'd1;
            end
            obs_data  = (sel != 0) ? {32'h0, l_data} : m_data;
            obs_valid = (sel != 0) ? l_valid : m_valid;
            obs_perr  = (sel != 0) ? l_perr : m_perr;
            obs_count = (sel != 0) ? l_count : m_count;
            if (obs_valid) begin
                prev_vcyc = last_vcyc;
                last_vcyc = cyc;
            end
            check_val("frame_valid", 64'(obs_valid), 64'(i == end_idx && !bad));
            check_val("parity_err", 64'(obs_perr), 64'(i == end_idx && bad));
            check_val("data_out", obs_data, exp_data[sel]);
            check_val("frame_count", 64'(obs_count), 64'(exp_count[sel]));
        end
        sync = 1'b0;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        do_reset();

        send_frame(0, 32'h12345678, 32'h9ABCDEF0, M_FL, 1'b0, -1);
        check_val("t1_data", m_data, 64'h9ABCDEF0_12345678);
        check_val("t1_count", 64'(m_count), 64'd1);

        send_frame(0, 32'hFFFFFFFF, $urandom, M_FL, 1'b0, -1);
        check_val("t2_gap", 64'(last_vcyc - prev_vcyc), 64'(M_FL));
        check_val("t2_count", 64'(m_count), 64'd2);

        // Sync part-way through the window, then a clean frame timed from the sync.
        send_frame(0, $urandom, $urandom, 140, 1'b0, -1);
        a = $urandom;
        b = $urandom;
        send_frame(0, a, b, M_FL, 1'b1, -1);
        check_val("t3_data", m_data, {b, a});
        check_val("t3_count", 64'(m_count), 64'd3);

        // Sync landing exactly on the update edge suppresses that update.
        send_frame(0, $urandom, $urandom, M_END, 1'b0, -1);
        send_frame(0, $urandom, $urandom, M_FL, 1'b1, -1);

        // Reset in the middle of capture, then a full frame from reset.
        send_frame(0, $urandom, $urandom, 150, 1'b0, -1);
        do_reset();
        a = $urandom;
        b = $urandom;
        send_frame(0, a, b, M_FL, 1'b0, -1);
        check_val("t4_data", m_data, {b, a});
        check_val("t4_count", 64'(m_count), 64'd1);

        repeat (4) send_frame(0, $urandom, $urandom, M_FL, 1'($urandom_range(0, 1)), -1);

`ifdef READER_PARITY_EN
        a = $urandom;
        b = $urandom;
        send_frame(0, a, b, M_FL, 1'b1, 1);
        send_frame(0, a, b, M_FL, 1'b0, -1);
        check_val("t6_data", m_data, {b, a});
        send_frame(0, $urandom, $urandom, M_FL, 1'b0, 0);
`endif

        do_reset();
        send_frame(1, 32'h00000001, 32'h0, L_FL, 1'b0, -1);
        check_val("t5_data", 64'(l_data), 64'h1);
        repeat (3) send_frame(1, $urandom, 32'h0, L_FL, 1'($urandom_range(0, 1)), -1);
        check_val("t5_count", 64'(l_count), 64'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
